// File: rtl/frame_grid_sampler_if.sv
// Frame-grid sampler bus: start request, frame-buffer read port,
// packed grid output and pass status.
interface frame_grid_sampler_if #(
    parameter int GRID = 25
);
    logic                       start;
    logic [16:0]                rd_addr;
    logic [11:0]                rd_data;
    logic [GRID*GRID*12-1:0]    cam;
    logic                       busy;
    logic                       done;

    modport master (
        output start, rd_data,
        input  rd_addr, cam, busy, done
    );

    modport slave (
        input  start, rd_data,
        output rd_addr, cam, busy, done
    );
endinterface

// File: rtl/frame_grid_sampler.sv
// Samples a GRID x GRID lattice of RGB444 pixels out of a frame buffer
// and publishes the whole grid atomically on cam.
module frame_grid_sampler #(
    parameter int LINE_WIDTH = 320,
    parameter int GRID       = 25,
    parameter int ROW_STRIDE = 9,
    parameter int COL_STRIDE = 12,
    parameter int RD_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    frame_grid_sampler_if.slave bus
);
    localparam int NPIX = GRID * GRID;
    localparam int KW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [KW-1:0] LAST_K   = KW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_C   = CW'(GRID - 1);
    localparam logic [16:0]   ROW_STEP = 17'(ROW_STRIDE * LINE_WIDTH);
    localparam logic [16:0]   COL_STEP = 17'(COL_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]  k_q;
    logic [CW-1:0]  col_q, col_d;
    logic [16:0]    rbase_q, rbase_d;
    logic [16:0]    coff_q, coff_d;
    logic [16:0]    rd_addr_q;

    logic [RD_LATENCY-1:0]          pv_q;
    logic [RD_LATENCY-1:0][KW-1:0]  pk_q;
    logic                           cap_v;
    logic [KW-1:0]                  cap_k;
    logic                           last_cap;

    logic [NPIX*12-1:0] shadow_q;
    logic [NPIX*12-1:0] cam_q;

    assign cap_v    = pv_q[RD_LATENCY-1];
    assign cap_k    = pk_q[RD_LATENCY-1];
    assign last_cap = cap_v && (cap_k == LAST_K);

    assign bus.rd_addr = rd_addr_q;
    assign bus.cam     = cam_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = READ;
            READ:    if (k_q == LAST_K) state_d = DRAIN;
            DRAIN:   if (last_cap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next lattice point from running row base and column offset.
    always_comb begin
        col_d   = col_q + CW'(1);
        rbase_d = rbase_q;
        coff_d  = coff_q + COL_STEP;
        if (col_q == LAST_C) begin
            col_d   = '0;
            rbase_d = rbase_q + ROW_STEP;
            coff_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            col_q     <= '0;
            rbase_q   <= '0;
            coff_q    <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                k_q       <= '0;
                col_q     <= '0;
                rbase_q   <= '0;
                coff_q    <= '0;
                rd_addr_q <= '0;
            end else if (state_q == READ && k_q != LAST_K) begin
                k_q       <= k_q + KW'(1);
                col_q     <= col_d;
                rbase_q   <= rbase_d;
                coff_q    <= coff_d;
                rd_addr_q <= rbase_d + coff_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            pk_q <= '0;
        end else begin
            pv_q[0] <= (state_q == READ);
            pk_q[0] <= k_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pk_q[i] <= pk_q[i-1];
            end
        end
    end

    // cam loads on the edge into DONE, folding in the last pixel as it
    // arrives, so the grid is already complete while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cam_q    <= '0;
        end else begin
            if (cap_v)
                shadow_q[int'(cap_k)*12 +: 12] <= bus.rd_data;
            if (state_q == DRAIN && last_cap)
                cam_q <= {bus.rd_data, shadow_q[(NPIX-1)*12-1:0]};
        end
    end
endmodule

// File: tb/tb_frame_grid_sampler.sv
// Bench for frame_grid_sampler: two instances (read latency 1 and 2)
// checked every cycle against a timeline model of a sampling pass.
module tb_frame_grid_sampler;
    localparam int LW   = 320;
    localparam int G    = 25;
    localparam int RS   = 9;
    localparam int CS   = 12;
    localparam int NP   = G * G;
    localparam int CAMW = NP * 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    bit   mode = 1'b0;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_grid_sampler_if #(.GRID(G)) bus0 ();
    frame_grid_sampler_if #(.GRID(G)) bus1 ();

    frame_grid_sampler #(
        .LINE_WIDTH(LW), .GRID(G), .ROW_STRIDE(RS),
        .COL_STRIDE(CS), .RD_LATENCY(1)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    frame_grid_sampler #(
        .LINE_WIDTH(LW), .GRID(G), .ROW_STRIDE(RS),
        .COL_STRIDE(CS), .RD_LATENCY(2)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [11:0] mem(logic [16:0] a);
        return mode ? ~a[11:0] : a[11:0];
    endfunction

    logic [11:0] d1_0, d1_1, d2_1;
    always @(posedge clk) begin
        d1_0 <= mem(bus0.rd_addr);
        d1_1 <= mem(bus1.rd_addr);
        d2_1 <= d1_1;
    end

    assign bus0.start   = start;
    assign bus1.start   = start;
    assign bus0.rd_data = d1_0;
    assign bus1.rd_data = d2_1;

    function automatic int addr_of(int k);
        return (k / G) * RS * LW + (k % G) * CS;
    endfunction

    function automatic logic [CAMW-1:0] grid_of(bit inv);
        logic [CAMW-1:0] g;
        logic [31:0] a;
        g = '0;
        for (int k = 0; k < NP; k++) begin
            a = addr_of(k);
            g[k*12 +: 12] = inv ? ~a[11:0] : a[11:0];
        end
        return g;
    endfunction

    function automatic logic [11:0] pix(logic [CAMW-1:0] c, int k);
        return c[k*12 +: 12];
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s[lat%0d] cyc=%0d got=%0h want=%0h",
                     nm, i + 1, cyc, act, exp);
        end
    endtask

    // Timeline model: n = cycles since the start was accepted.
    bit              m_act [2];
    int              m_n   [2];
    bit              m_inv [2];
    logic [16:0]     m_addr[2];
    logic [CAMW-1:0] m_cam [2];
    int              dcnt  [2];
    int              dcyc  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_n[i] = 0; m_inv[i] = 0;
            m_addr[i] = '0; m_cam[i] = '0;
            dcnt[i] = 0; dcyc[i] = -1;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]  = 0;
                m_n[i]    = 0;
                m_addr[i] = '0;
                m_cam[i]  = '0;
            end else if (m_act[i]) begin
                m_n[i]++;
                if (m_n[i] > 626 + (i + 1)) m_act[i] = 0;
            end else if (start) begin
                m_act[i] = 1;
                m_n[i]   = 1;
                m_inv[i] = mode;
            end
            if (m_act[i] && m_n[i] >= 1 && m_n[i] <= NP)
                m_addr[i] = 17'(addr_of(m_n[i] - 1));
            if (m_act[i] && m_n[i] == 626 + (i + 1))
                m_cam[i] = grid_of(m_inv[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic            b, d;
                logic [16:0]     a;
                logic [CAMW-1:0] c;
                b = (i == 0) ? bus0.busy : bus1.busy;
                d = (i == 0) ? bus0.done : bus1.done;
                a = (i == 0) ? bus0.rd_addr : bus1.rd_addr;
                c = (i == 0) ? bus0.cam : bus1.cam;
                chk("busy", i, 32'(b), 32'(m_act[i]));
                chk("done", i, 32'(d),
                    32'(m_act[i] && m_n[i] == 626 + (i + 1)));
                chk("rd_addr", i, 32'(a), 32'(m_addr[i]));
                if (m_act[i] && m_n[i] >= 1 && m_n[i] <= NP)
                    chk("addr_range", i, 32'(a <= 17'd76799), 32'd1);
                vec++;
                if (c !== m_cam[i]) begin
                    miss++;
                    for (int k = 0; k < NP; k++) begin
                        if (pix(c, k) !== pix(m_cam[i], k)) begin
                            $display("FAIL cam[lat%0d] cyc=%0d pixel %0d got=%0h want=%0h",
                                     i + 1, cyc, k, pix(c, k), pix(m_cam[i], k));
                            break;
                        end
                    end
                end
                if (d === 1'b1) begin
                    dcnt[i]++;
                    dcyc[i] = cyc;
                end
            end
        end
    end

    task automatic wait_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_at(int c);
        wait_to(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    int t;

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 0, 32'(bus0.busy), 32'd0);
        chk("rst_cam", 0, 32'(bus0.cam == '0), 32'd1);
        chk("rst_addr", 1, 32'(bus1.rd_addr), 32'd0);
        rst = 1'b0;

        t = cyc + 2;
        start_at(t);
        start_at(t + 10);
        start_at(t + 300);
        start_at(t + 627);
        wait_to(t + 700);
        chk("done_cyc", 0, 32'(dcyc[0]), 32'(t + 627));
        chk("done_cyc", 1, 32'(dcyc[1]), 32'(t + 628));
        chk("done_cnt", 0, 32'(dcnt[0]), 32'd1);
        chk("done_cnt", 1, 32'(dcnt[1]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            logic [CAMW-1:0] c;
            c = (i == 0) ? bus0.cam : bus1.cam;
            chk("pix0", i, 32'(pix(c, 0)), 32'd0);
            chk("pix1", i, 32'(pix(c, 1)), 32'd12);
            chk("pix25", i, 32'(pix(c, 25)), 32'd2880);
            chk("pix624", i, 32'(pix(c, 624)), 32'd3872);
        end

        mode = 1'b1;
        t = cyc + 2;
        start_at(t);
        wait_to(t + 626);
        chk("hold_pix1", 0, 32'(pix(bus0.cam, 1)), 32'd12);
        chk("hold_pix1", 1, 32'(pix(bus1.cam, 1)), 32'd12);
        wait_to(t + 627);
        chk("new_pix1", 0, 32'(pix(bus0.cam, 1)), 32'hFF3);
        chk("hold_pix1b", 1, 32'(pix(bus1.cam, 1)), 32'd12);
        wait_to(t + 700);
        chk("new_pix1", 1, 32'(pix(bus1.cam, 1)), 32'hFF3);
        chk("done_cnt2", 0, 32'(dcnt[0]), 32'd2);

        t = cyc + 2;
        start_at(t);
        wait_to(t + 300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 0, 32'(bus0.busy), 32'd0);
        chk("abort_cam", 1, 32'(bus1.cam == '0), 32'd1);
        wait_to(t + 1301);
        chk("abort_done", 0, 32'(dcnt[0]), 32'd2);
        chk("abort_done", 1, 32'(dcnt[1]), 32'd2);

        t = cyc + 2;
        start_at(t);
        wait_to(t + 700);
        chk("done_cyc3", 0, 32'(dcyc[0]), 32'(t + 627));
        chk("done_cyc3", 1, 32'(dcyc[1]), 32'(t + 628));
        chk("done_cnt3", 1, 32'(dcnt[1]), 32'd3);
        chk("pix1_3", 0, 32'(pix(bus0.cam, 1)), 32'hFF3);
        chk("pix624_3", 1, 32'(pix(bus1.cam, 624)), 32'h0DF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
